// File: rtl/lane_packer_pkg.sv
// lane_packer_pkg
//   Shared constants and helpers for the lane packer.
//   COUNT_W     : width of the emitted-word counter.
//   lane_offset : bit offset of lane i inside the packed output word;
//                 lane order flips when reverse is non-zero.
package lane_packer_pkg;

  localparam int COUNT_W = 16;

  function automatic int lane_offset(input int lane, input int lanes,
                                     input int width, input int reverse);
    return (reverse != 0) ? (lanes - 1 - lane) * width : lane * width;
  endfunction

endpackage

// File: rtl/lane_packer_slot.sv
// lane_packer_slot
//   One-entry holding slot for a single input lane.
//   Ports:
//     clk, rst   : clock and synchronous active-high reset
//     in_valid   : lane valid
//     in_data    : lane data
//     clear      : join is firing this cycle; the slot empties at the edge
//                  unless it refills at that same edge
//     in_ready   : lane ready (empty, or being emptied this cycle)
//     full       : slot holds data
//     data       : held data
module lane_packer_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             in_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;
  logic             accept;

  // A slot that is being drained by the join can take the next item at the
  // same edge, which is what allows one packed word per cycle.
  assign in_ready = !full_reg || clear;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (accept) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end else if (clear) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign data = data_reg;

endmodule

// File: rtl/lane_packer.sv
// lane_packer
//   Gathers one item from each of LANES independent valid/ready lanes and
//   emits them joined as a single packed word through an output register.
//   Parameters:
//     LANES   : number of lanes joined per word (1..16)
//     WIDTH   : bits per lane
//     REVERSE : 0 -> lane 0 in the LSBs, 1 -> lane 0 in the MSBs
//   Ports:
//     clk, rst   : clock and synchronous active-high reset
//     in_valid   : per-lane valid
//     in_data    : lane i at bits [i*WIDTH +: WIDTH]
//     in_ready   : per-lane ready
//     out_valid  : packed word valid
//     out_data   : packed word
//     out_ready  : downstream ready
//     out_count  : number of words handed downstream (wraps)
//     out_parity : XOR of all out_data bits (only with LANE_PACKER_PARITY_EN)
//   Build option: define LANE_PACKER_PARITY_EN to add the out_parity port.
module lane_packer
  import lane_packer_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int REVERSE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       in_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  output logic [COUNT_W-1:0]     out_count
`ifdef LANE_PACKER_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int W = LANES * WIDTH;

  logic [LANES-1:0] slot_full;
  logic [WIDTH-1:0] slot_data [LANES];
  logic [W-1:0]     packed_word;
  logic             join_fire;

  logic               out_valid_reg;
  logic [W-1:0]       out_data_reg;
  logic [COUNT_W-1:0] out_count_reg;

  // Join when every lane has something and the output register is free or
  // being drained this cycle.
  assign join_fire = (&slot_full) && (!out_valid_reg || out_ready);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int OFF = lane_offset(gi, LANES, WIDTH, REVERSE);

      lane_packer_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid[gi]),
        .in_data  (in_data[gi*WIDTH +: WIDTH]),
        .clear    (join_fire),
        .in_ready (in_ready[gi]),
        .full     (slot_full[gi]),
        .data     (slot_data[gi])
      );

      assign packed_word[OFF +: WIDTH] = slot_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (join_fire) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= packed_word;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      out_count_reg <= out_count_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

`ifdef LANE_PACKER_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (join_fire) begin
      parity_reg <= ^packed_word;
    end
  end

  assign out_parity = parity_reg;
`endif

endmodule
